capture_ctrl: RTL and testbench

- Sequences capture of 4-channel ADC sample frames into the shared 4096x8 single-port sample RAM. Also arbitrates that RAM's one port between capture writes and host readout.
- Sits between adc_sampler (ch0..ch3, newSample) and the ram4096x8 instance, replacing the free-running address counter.
- On arm, records one full buffer (1024 frames, channel-interleaved), then freezes it for readout until re-armed.

---
 rtl/capture_ctrl.sv | 153 +++++++++++++++
 tb/tb_capture_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// Capture sequencer for 4-channel ADC frames into a shared single-port sample RAM,
// with arbitration of the RAM port between capture writes and host readout.
module capture_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              arm,
  input  logic              abort,
  input  logic              new_sample,
  input  logic [7:0]        ch0,
  input  logic [7:0]        ch1,
  input  logic [7:0]        ch2,
  input  logic [7:0]        ch3,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  input  logic [7:0]        ram_q,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [ADDR_W-2:0] frame_cnt,
  output logic [1:0]        state_dbg
);

  localparam int NCH    = 4;
  localparam int FRAMES = (2 ** ADDR_W) / NCH;
  localparam logic [ADDR_W-2:0] FRAME_LAST = (ADDR_W-1)'(FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [2:0]      sync;
  logic            sample_edge;
  logic [1:0]      k;
  logic [3:0][7:0] hold;
  logic            rd_p1;
  logic            rd_p2;

  // Two flops resynchronise new_sample; the third holds the previous level for edge detect.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[1:0], new_sample};
    end
  end

  assign sample_edge = sync[1] & ~sync[2];
  assign state_dbg   = state;

  // Handshake: rd_req is accepted only in S_DONE with no read in its address phase;
  // rd_valid then pulses for one cycle two edges after acceptance with rd_data valid.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= S_IDLE;
      k         <= '0;
      hold      <= '0;
      rd_p1     <= 1'b0;
      rd_p2     <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_wren  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      rd_valid <= 1'b0;
      ram_wren <= 1'b0;
      rd_p2    <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
        rd_p1 <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm) begin
              state     <= S_ARMED;
              frame_cnt <= '0;
              overrun   <= 1'b0;
              busy      <= 1'b1;
            end
          end
          S_ARMED: begin
            if (sample_edge) begin
              hold  <= {ch3, ch2, ch1, ch0};
              k     <= 2'd0;
              state <= S_WRITE;
            end
          end
          S_WRITE: begin
            ram_wren <= 1'b1;
            ram_addr <= {frame_cnt[ADDR_W-3:0], k};
            ram_data <= hold[k];
            k        <= k + 2'd1;
            // A frame edge arriving while the previous frame is still being written is lost.
            if (sample_edge) begin
              overrun <= 1'b1;
            end
            if (k == 2'd3) begin
              frame_cnt <= frame_cnt + 1'b1;
              if (frame_cnt == FRAME_LAST) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= S_ARMED;
              end
            end
          end
          S_DONE: begin
            if (arm) begin
              state     <= S_ARMED;
              frame_cnt <= '0;
              overrun   <= 1'b0;
              busy      <= 1'b1;
              done      <= 1'b0;
              rd_p1     <= 1'b0;
            end else begin
              if (rd_p2) begin
                rd_data  <= ram_q;
                rd_valid <= 1'b1;
              end
              if (rd_req && !rd_p1) begin
                ram_addr <= rd_addr;
                rd_p1    <= 1'b1;
              end else begin
                rd_p1 <= 1'b0;
              end
              rd_p2 <= rd_p1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: randomized frame timing and host reads, checked against a
// queue-based model of the expected RAM writes and read returns.
module tb_capture_ctrl;
  localparam int ADDR_W = 12;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              n_reset;
  logic              arm, abort, new_sample;
  logic [7:0]        ch0, ch1, ch2, ch3;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_wren;
  logic [7:0]        ram_q;
  logic              busy, done, overrun;
  logic [ADDR_W-2:0] frame_cnt;
  logic [1:0]        state_dbg;

  capture_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .n_reset(n_reset), .arm(arm), .abort(abort), .new_sample(new_sample),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy), .done(done), .overrun(overrun), .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  // sample RAM with 1-clock read latency
  logic [7:0] ram_mem [4096];
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [19:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  int          due_q[$];
  logic [7:0]  exp_mem [4096];
  logic [7:0]  model_rd = 8'h00;
  bit          model_done = 0;
  bit          capturing = 0;
  int          last_acc = -10;
  int          mf = 0;
  int          errors = 0;
  int          checks = 0;
  int          wr_seen = 0;
  bit          chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: writes in order, read returns at their due cycle, rd_data holding
  initial begin : compare
    logic [19:0] e;
    bit          exp_v;
    forever begin
      @(posedge clk);
      #2;
      if (chk_en) begin
        if (ram_wren === 1'b1) begin
          wr_seen++;
          if (exp_wr_q.size() == 0) begin
            check("unexpected_write_addr", 32'(ram_addr), 32'hFFFF_FFFF);
          end else begin
            e = exp_wr_q.pop_front();
            check("wr_addr", 32'(ram_addr), 32'(e[19:8]));
            check("wr_data", 32'(ram_data), 32'(e[7:0]));
          end
        end
        while (due_q.size() > 0 && due_q[0] < cyc) begin
          void'(due_q.pop_front());
          void'(exp_rd_q.pop_front());
        end
        exp_v = (due_q.size() > 0 && due_q[0] == cyc);
        check("rd_valid", 32'(rd_valid), 32'(exp_v));
        if (exp_v) begin
          model_rd = exp_rd_q.pop_front();
          void'(due_q.pop_front());
        end
        check("rd_data", 32'(rd_data), 32'(model_rd));
      end
    end
  end

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  initial begin : watchdog
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    summary();
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic push_frame(input logic [7:0] v0, v1, v2, v3);
    logic [7:0] v [4];
    logic [11:0] a;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int c = 0; c < 4; c++) begin
      a = 12'(mf * 4 + c);
      exp_wr_q.push_back({a, v[c]});
      exp_mem[a] = v[c];
    end
    mf++;
  endtask

  task automatic send_frame(input logic [7:0] v0, v1, v2, v3);
    int hi, gap;
    push_frame(v0, v1, v2, v3);
    ch0 = v0; ch1 = v1; ch2 = v2; ch3 = v3;
    hi  = $urandom_range(1, 3);
    gap = $urandom_range(12, 18);
    new_sample = 1'b1;
    repeat (hi) tick();
    new_sample = 1'b0;
    repeat (gap - hi) tick();
  endtask

  task automatic pulse_ctrl(input bit a_arm, input bit a_abort);
    arm = a_arm;
    abort = a_abort;
    if (a_abort || (a_arm && model_done)) begin
      due_q.delete();
      exp_rd_q.delete();
    end
    if (a_abort) begin
      capturing = 0;
      model_done = 0;
    end else if (a_arm && !capturing) begin
      capturing = 1;
      model_done = 0;
      mf = 0;
    end
    tick();
    arm = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a);
    int n;
    rd_req = 1'b1;
    rd_addr = a;
    n = cyc + 1;
    if (model_done && n - last_acc >= 2) begin
      last_acc = n;
      due_q.push_back(n + 2);
      exp_rd_q.push_back(exp_mem[a]);
    end
    tick();
    rd_req = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("done_reached", 32'(done), 32'd1);
    repeat (2) tick();
    capturing = 0;
    model_done = (mf == 1024);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_data"}, 32'(ram_data), 32'd0);
    check({tag, "_ram_wren"}, 32'(ram_wren), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin : stim
    int n;
    int snap;
    n_reset = 1'b0; arm = 0; abort = 0; new_sample = 0;
    ch0 = 0; ch1 = 0; ch2 = 0; ch3 = 0; rd_req = 0; rd_addr = 0;
    repeat (3) tick();
    check_zero("reset");
    n_reset = 1'b1;
    chk_en = 1;
    tick();

    // reset in the middle of a frame write
    pulse_ctrl(1, 0);
    check("armed_busy", 32'(busy), 32'd1);
    push_frame(8'h11, 8'h22, 8'h33, 8'h44);
    ch0 = 8'h11; ch1 = 8'h22; ch2 = 8'h33; ch3 = 8'h44;
    new_sample = 1'b1;
    n = 0;
    while (ram_wren !== 1'b1 && n < 20) begin tick(); n++; end
    check("first_write_seen", 32'(ram_wren), 32'd1);
    tick();
    tick();
    #2;
    n_reset = 1'b0;
    #1;
    chk_en = 0;
    check_zero("midwrite_reset");
    exp_wr_q.delete(); due_q.delete(); exp_rd_q.delete();
    model_rd = 8'h00; capturing = 0; model_done = 0; mf = 0;
    new_sample = 1'b0;
    repeat (3) tick();
    n_reset = 1'b1;
    chk_en = 1;
    repeat (2) tick();

    // short capture: normal frames, an overrun, then abort inside frame 5
    pulse_ctrl(1, 0);
    for (int f = 0; f < 3; f++)
      send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    check("cnt_after3", 32'(frame_cnt), 32'd3);
    check("no_overrun_yet", 32'(overrun), 32'd0);
    push_frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    ch0 = 8'hA0; ch1 = 8'hA1; ch2 = 8'hA2; ch3 = 8'hA3;
    new_sample = 1'b1; tick();
    new_sample = 1'b0; tick();
    new_sample = 1'b1; tick();
    new_sample = 1'b0;
    repeat (16) tick();
    check("overrun_set", 32'(overrun), 32'd1);
    check("cnt_after_overrun", 32'(frame_cnt), 32'd4);
    send_frame(8'h40, 8'h41, 8'h42, 8'h43);
    check("cnt_after5", 32'(frame_cnt), 32'd5);
    check("overrun_sticky", 32'(overrun), 32'd1);

    exp_wr_q.push_back({12'h014, 8'h5A});
    ch0 = 8'h5A; ch1 = 8'h5B; ch2 = 8'h5C; ch3 = 8'h5D;
    new_sample = 1'b1;
    n = 0;
    while (ram_wren !== 1'b1 && n < 20) begin tick(); n++; end
    check("frame5_write_seen", 32'(ram_wren), 32'd1);
    pulse_ctrl(0, 1);
    new_sample = 1'b0;
    check("abort_wren", 32'(ram_wren), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cnt", 32'(frame_cnt), 32'd5);
    check("abort_overrun_held", 32'(overrun), 32'd1);
    check("abort_ram_addr", 32'(ram_addr), 32'h014);
    repeat (4) tick();
    check("abort_no_more_writes", 32'(exp_wr_q.size()), 32'd0);

    // host reads outside DONE are ignored
    do_read(12'hABC);
    tick();
    check("idle_read_addr", 32'(ram_addr), 32'h014);
    pulse_ctrl(1, 0);
    check("rearm_overrun", 32'(overrun), 32'd0);
    check("rearm_cnt", 32'(frame_cnt), 32'd0);
    check("rearm_busy", 32'(busy), 32'd1);
    do_read(12'h123);
    tick();
    check("armed_read_addr", 32'(ram_addr), 32'h014);

    // full capture, channel value = frame index + channel
    snap = wr_seen;
    for (int f = 0; f < 1024; f++)
      send_frame(8'(f), 8'(f + 1), 8'(f + 2), 8'(f + 3));
    wait_done();
    check("full_wren_cycles", 32'(wr_seen - snap), 32'd4096);
    check("full_cnt", 32'(frame_cnt), 32'd1024);
    check("full_overrun", 32'(overrun), 32'd0);
    check("full_busy", 32'(busy), 32'd0);
    check("full_writes_drained", 32'(exp_wr_q.size()), 32'd0);

    // read 0x00A (frame 2, ch2), second request one cycle later is ignored
    do_read(12'h00A);
    do_read(12'h00B);
    tick();
    check("read_a_valid", 32'(rd_valid), 32'd1);
    check("read_a_data", 32'(rd_data), 32'h04);
    tick();
    check("read_b_ignored", 32'(rd_valid), 32'd0);
    check("read_data_held", 32'(rd_data), 32'h04);
    for (int i = 0; i < 60; i++) begin
      do_read(12'($urandom_range(0, 4095)));
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (4) tick();

    // arm and abort together in DONE: abort wins
    pulse_ctrl(1, 1);
    check("armabort_done", 32'(done), 32'd0);
    check("armabort_busy", 32'(busy), 32'd0);
    check("armabort_cnt_held", 32'(frame_cnt), 32'd1024);

    // second capture with random data; an arm while ARMED is ignored
    pulse_ctrl(1, 0);
    for (int f = 0; f < 1024; f++) begin
      if (f == 500) pulse_ctrl(1, 0);
      send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    wait_done();
    check("cap2_cnt", 32'(frame_cnt), 32'd1024);
    for (int i = 0; i < 40; i++) begin
      do_read(12'($urandom_range(0, 4095)));
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (4) tick();

    // arm right after a read is accepted cancels it
    do_read(12'h7FF);
    pulse_ctrl(1, 0);
    check("cancel_busy", 32'(busy), 32'd1);
    check("cancel_done", 32'(done), 32'd0);
    repeat (4) tick();
    pulse_ctrl(0, 1);
    repeat (2) tick();
    check("end_writes_drained", 32'(exp_wr_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
